// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation codes, FSM state type and default busy-cycle counts.
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8,
    OpMadd  = 4'd9,
    OpMaddu = 4'd10
  } mdu_op_e;

  typedef enum logic {
    StIdle,
    StBusy
  } mdu_state_e;

  localparam int unsigned DefMultCycles = 5;
  localparam int unsigned DefDivCycles  = 10;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers and a fixed-latency busy period.
// Build option: define MDU_MADD_EN to accept MADD/MADDU (64-bit accumulate into HI/LO).
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefMultCycles,
  parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] rd_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

`ifdef MDU_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     rs_q, rs_d, rt_q, rt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic is_madd, is_mult, is_div, is_mdu;

  always_comb begin
    is_madd = MaddEn && ((mdu_op == OpMadd) || (mdu_op == OpMaddu));
    is_mult = (mdu_op == OpMult) || (mdu_op == OpMultu) || is_madd;
    is_div  = (mdu_op == OpDiv) || (mdu_op == OpDivu);
    is_mdu  = is_mult || is_div || (mdu_op == OpMfhi) || (mdu_op == OpMflo) ||
              (mdu_op == OpMthi) || (mdu_op == OpMtlo);
  end

  // Arithmetic works only on the latched operands.
  logic [63:0] prod_s, prod_u, acc;
  logic [31:0] rs_mag, rt_mag, div_s_den, div_u_den;
  logic [31:0] sq_mag, sr_mag, quot_s, rem_s, quot_u, rem_u;

  always_comb begin
    prod_s = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q});
    prod_u = {32'd0, rs_q} * {32'd0, rt_q};
    acc    = {hi_q, lo_q} + (((op_q == OpMadd)) ? prod_s : prod_u);

    // Sign-magnitude division: truncation toward zero, remainder follows dividend,
    // and 0x80000000 / -1 wraps back to 0x80000000 naturally.
    rs_mag    = rs_q[31] ? (32'd0 - rs_q) : rs_q;
    rt_mag    = rt_q[31] ? (32'd0 - rt_q) : rt_q;
    div_s_den = (rt_q == 32'd0) ? 32'd1 : rt_mag;
    div_u_den = (rt_q == 32'd0) ? 32'd1 : rt_q;
    sq_mag    = rs_mag / div_s_den;
    sr_mag    = rs_mag % div_s_den;
    quot_s    = (rs_q[31] ^ rt_q[31]) ? (32'd0 - sq_mag) : sq_mag;
    rem_s     = rs_q[31] ? (32'd0 - sr_mag) : sr_mag;
    quot_u    = rs_q / div_u_den;
    rem_u     = rs_q % div_u_den;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_mult || is_div) begin
            op_d    = mdu_op;
            rs_d    = rs_data;
            rt_d    = rt_data;
            cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_d = StBusy;
          end else if (mdu_op == OpMthi) begin
            hi_d = rs_data;
          end else if (mdu_op == OpMtlo) begin
            lo_d = rs_data;
          end
        end
      end
      StBusy: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          case (op_q)
            OpMult:  {hi_d, lo_d} = prod_s;
            OpMultu: {hi_d, lo_d} = prod_u;
            OpMadd, OpMaddu: {hi_d, lo_d} = acc;
            OpDiv: if (rt_q != 32'd0) begin
              hi_d = rem_s;
              lo_d = quot_s;
            end
            OpDivu: if (rt_q != 32'd0) begin
              hi_d = rem_u;
              lo_d = quot_u;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    busy      = (state_q == StBusy);
    stall_req = busy || (start && is_mdu);
    hi_out    = hi_q;
    lo_out    = lo_q;
    rd_data   = 32'd0;
    if (mdu_op == OpMfhi) begin
      rd_data = hi_q;
    end else if (mdu_op == OpMflo) begin
      rd_data = lo_q;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: multiply, divide, MTHI/MTLO, hazards, reset abort.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, stall_req;
  logic [31:0] rd_data, hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .stall_req (stall_req),
    .rd_data   (rd_data),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  // Issue one op for one cycle (caller sits at a negedge); count busy cycles afterwards.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    start   = 1'b1;
    mdu_op  = op;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start   = 1'b0;
    mdu_op  = OpNone;
    rs_data = 32'hDEAD_BEEF;
    rt_data = 32'hCAFE_F00D;
    cycles  = 0;
    while (busy && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_out); end
    n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_out); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    @(negedge clk);
  endtask

  task automatic test_mult();
    int cyc;
    run_op(OpMult, 32'hFFFF_FFFF, 32'd2, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL mult_cycles: got %0d want 5", cyc); end
    n_checks++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi_out); end
    n_checks++; if (lo_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffe", lo_out); end
    mdu_op = OpMfhi;
    #1;
    n_checks++; if (rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mfhi_rd: got %h want ffffffff", rd_data); end
    mdu_op = OpMflo;
    start  = 1'b1;
    #1;
    n_checks++; if (rd_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mflo_rd: got %h want fffffffe", rd_data); end
    n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL mflo_stall: got %b want 1", stall_req); end
    @(negedge clk);
    start  = 1'b0;
    mdu_op = OpNone;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mflo_nobusy: got %b want 0", busy); end
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL none_rd: got %h want 0", rd_data); end
  endtask

  task automatic test_multu();
    int cyc;
    run_op(OpMultu, 32'hFFFF_FFFF, 32'd2, cyc);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL multu_cycles: got %0d want 5", cyc); end
    n_checks++; if (hi_out !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h want 00000001", hi_out); end
    n_checks++; if (lo_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", lo_out); end
  endtask

  task automatic test_div();
    int cyc;
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, cyc);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL div_cycles: got %0d want 10", cyc); end
    n_checks++; if (lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo_out); end
    n_checks++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi_out); end
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_checks++; if (lo_out !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", lo_out); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h want 0", hi_out); end
    run_op(OpDivu, 32'd100, 32'd7, cyc);
    n_checks++; if (lo_out !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", lo_out); end
    n_checks++; if (hi_out !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", hi_out); end
  endtask

  task automatic test_div_zero();
    int cyc;
    run_op(OpMthi, 32'h11, 32'd0, cyc);
    n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL mthi_busy: got %0d want 0", cyc); end
    run_op(OpMtlo, 32'h22, 32'd0, cyc);
    n_checks++; if (hi_out !== 32'h11) begin n_fail++; $display("FAIL mthi_val: got %h want 00000011", hi_out); end
    n_checks++; if (lo_out !== 32'h22) begin n_fail++; $display("FAIL mtlo_val: got %h want 00000022", lo_out); end
    run_op(OpDivu, 32'd7, 32'd0, cyc);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL div0_cycles: got %0d want 10", cyc); end
    n_checks++; if (hi_out !== 32'h11) begin n_fail++; $display("FAIL div0_hi: got %h want 00000011", hi_out); end
    n_checks++; if (lo_out !== 32'h22) begin n_fail++; $display("FAIL div0_lo: got %h want 00000022", lo_out); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int stall_bad;
    start   = 1'b1;
    mdu_op  = OpMult;
    rs_data = 32'hFFFF_FFFF;
    rt_data = 32'd3;
    @(negedge clk);
    start   = 1'b0;
    mdu_op  = OpNone;
    cyc       = 1;
    stall_bad = 0;
    @(negedge clk);
    cyc++;
    // DIV held upstream by the hazard unit while the MULT is in flight
    start   = 1'b1;
    mdu_op  = OpDiv;
    rs_data = 32'd100;
    rt_data = 32'd7;
    while (busy && cyc < 50) begin
      #1;
      if (stall_req !== 1'b1) stall_bad++;
      @(negedge clk);
      if (busy) cyc++;
    end
    start  = 1'b0;
    mdu_op = OpNone;
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL b2b_stall: got %0d low cycles want 0", stall_bad); end
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 5", cyc); end
    n_checks++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_hi: got %h want ffffffff", hi_out); end
    n_checks++; if (lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL b2b_lo: got %h want fffffffd", lo_out); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_div_ignored: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    run_op(OpMthi, 32'h55, 32'd0, cyc);
    run_op(OpMtlo, 32'h66, 32'd0, cyc);
    start   = 1'b1;
    mdu_op  = OpDiv;
    rs_data = 32'd100;
    rt_data = 32'd7;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = OpNone;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h want 0", hi_out); end
    n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h want 0", lo_out); end
    repeat (15) @(negedge clk);
    n_checks++; if ({hi_out, lo_out} !== 64'd0) begin n_fail++; $display("FAIL abort_nowrite: got %h want 0", {hi_out, lo_out}); end
  endtask

  task automatic test_madd();
    int cyc;
    run_op(OpMthi, 32'd0, 32'd0, cyc);
    run_op(OpMtlo, 32'hFFFF_FFFF, 32'd0, cyc);
    start   = 1'b1;
    mdu_op  = OpMaddu;
    rs_data = 32'd1;
    rt_data = 32'd1;
    #1;
`ifdef MDU_MADD_EN
    n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL madd_stall: got %b want 1", stall_req); end
`else
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL madd_stall: got %b want 0", stall_req); end
`endif
    @(negedge clk);
    start  = 1'b0;
    mdu_op = OpNone;
    cyc    = 0;
    while (busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
`ifdef MDU_MADD_EN
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL madd_cycles: got %0d want 5", cyc); end
    n_checks++; if (hi_out !== 32'd1) begin n_fail++; $display("FAIL madd_hi: got %h want 00000001", hi_out); end
    n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL madd_lo: got %h want 0", lo_out); end
`else
    n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL madd_cycles: got %0d want 0", cyc); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL madd_hi: got %h want 0", hi_out); end
    n_checks++; if (lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL madd_lo: got %h want ffffffff", lo_out); end
`endif
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    mdu_op  = OpNone;
    rs_data = 32'd0;
    rt_data = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_madd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter: MULT_CYCLES, 5, busy-cycle count for MULT/MULTU/MADD/MADDU.
REQ-002 SHALL have parameter: DIV_CYCLES, 10, busy-cycle count for DIV/DIVU.
REQ-003 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port: start  in  1  E-stage instruction valid and not flushed this cycle.
REQ-006 SHALL have port: mdu_op  in  4  operation code from the shared package.
REQ-007 SHALL have port: rs_data  in  32  forwarded rs operand from the D/E pipeline register.
REQ-008 SHALL have port: rt_data  in  32  forwarded rt operand from the D/E pipeline register.
REQ-009 SHALL have port: busy  out  1  multi-cycle operation in progress.
REQ-010 SHALL have port: stall_req  out  1  combinational; busy OR (start AND mdu_op is any MDU-class op); drives D-stage stall.
REQ-011 SHALL have port: rd_data  out  32  combinational; HI for MFHI, LO for MFLO, else 0.
REQ-012 SHALL have port: hi_out / lo_out  out  32 each  current HI/LO registers.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-014 In IDLE with start=1 and a multi-cycle op: latch rs_data, rt_data, op; load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY at the same edge.
REQ-015 busy SHALL be 1 for exactly N consecutive cycles after the accepting edge (N = loaded count); counter decrements each BUSY cycle.
REQ-016 At the edge ending the Nth busy cycle: write HI/LO with the result, return to IDLE; the new values are visible on hi_out/lo_out and rd_data in the following cycle.
REQ-017 MULT: {HI,LO} = signed 32x32 -> 64 product; MULTU: unsigned product.
REQ-018 DIV: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; DIVU: unsigned.
REQ-019 Divisor 0 (DIV/DIVU): full busy period still elapses; HI and LO retain previous values.
REQ-020 DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-021 MTHI/MTLO in IDLE with start=1: write rs_data to HI/LO at that edge, no busy period.
REQ-022 start with any op while busy=1 SHALL be ignored (no latch, no HI/LO write); the hazard unit holds the instruction upstream.
REQ-023 start=0 or mdu_op=NONE: no state change.
REQ-024 Computation SHALL be performed on the latched operands only; input changes during BUSY have no effect.

Reset
REQ-025 reset=1 at an edge: FSM=IDLE, counter=0, HI=0, LO=0, latched operands=0; busy=0 the following cycle.
REQ-026 Reset during BUSY SHALL abort the operation with no HI/LO write; reset takes priority over start and completion at the same edge.

Configuration
REQ-027 Macro MDU_MADD_EN defined: MADD/MADDU accepted; {HI,LO} += signed/unsigned 64-bit product with 64-bit wrap-around, using MULT_CYCLES.
REQ-028 MDU_MADD_EN undefined: MADD/MADDU codes are treated as NONE (no busy period, stall_req=busy only, HI/LO unchanged).

Structure
REQ-029 Package mdu_pkg SHALL hold: 4-bit op codes (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10), the FSM state type, default cycle counts.
REQ-030 No sub-module; FSM, counter and arithmetic are kept in e_mdu.

Verification
REQ-031 MULT rs=0xFFFFFFFF rt=2 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-032 MULTU rs=0xFFFFFFFF rt=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-033 DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 with prior HI=0x11,LO=0x22 -> unchanged after 10 cycles.
REQ-034 MULT accepted, DIV issued 2 cycles later while busy -> DIV ignored; only the MULT result is written; stall_req stays 1 throughout.
REQ-035 reset asserted on cycle 3 of a DIV -> busy=0 next cycle, HI=LO=0, no later write.
REQ-036 With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU rs=1 rt=1 -> HI=1, LO=0; without the macro -> HI/LO unchanged, busy never set.
